param_ram: RTL and testbench

PARAM_RAM -- requirements
Module: param_ram

---
 rtl/param_ram.sv | 137 +++++++++++++
 tb/tb_param_ram.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/param_ram.sv
// -----------------------------------------------------------------------------
// param_ram -- single-port word RAM with byte-enable writes and a post-reset
// zero-fill sweep.
//
// After reset the array can be cleared one word per cycle (CLEAR state).
// Requests are refused during the sweep. Once it finishes, the block enters
// RUN and serves one request per cycle.
//
// Parameters
//   DATA_W       word width in bits (multiple of 8, >= 8)
//   ADDR_W       address width; depth = 2**ADDR_W
//   CLEAR_ON_RST 1: zero-fill after reset, 0: contents survive reset
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous reset, active-high
//   req       access request
//   we        1 = write, 0 = read (qualified by req)
//   addr      word address
//   data_in   write data
//   be        byte enables, bit i covers data_in[8i+7:8i]
//   ready     block accepts requests (registered, high only in RUN)
//   data_out  registered read data, holds between reads
//   rvalid    one-cycle pulse when data_out carries fresh read data
//   err       sticky: a request arrived while ready was low
// -----------------------------------------------------------------------------
module param_ram #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 8,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/8-1:0]   be,
    output logic                  ready,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rvalid,
    output logic                  err
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                clr_we;
    logic                ready_q;
    logic                err_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   dout_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Acceptance keys off the registered ready so the handshake seen on the
    // port is exactly the one the block acts on.
    logic acc_rd, acc_wr;
    assign acc_rd = req & ~we & ready_q;
    assign acc_wr = req &  we & ready_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                // Leave on the same edge that zeroes the top word.
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Control / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= (state_d == RUN);
            err_q     <= err_q | (req & ~ready_q);
            rvalid_q  <= acc_rd;
            if (acc_rd) begin
                dout_q <= mem[addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: not reset, so contents persist when the sweep is disabled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[clr_cnt_q] <= '0;
            end else if (acc_wr) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= data_in[8*b +: 8];
                    end
                end
            end
        end
    end

    assign ready    = ready_q;
    assign data_out = dout_q;
    assign rvalid   = rvalid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_param_ram.sv
module tb_param_ram;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        req, req2;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data_in;
    logic [1:0]  be;
    logic        ready, rvalid, err;
    logic [15:0] data_out;
    logic        ready2, rvalid2, err2;
    logic [15:0] data_out2;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    param_ram dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .data_in(data_in), .be(be), .ready(ready), .data_out(data_out),
        .rvalid(rvalid), .err(err)
    );

    param_ram #(.DATA_W(16), .ADDR_W(8), .CLEAR_ON_RST(0)) dut2 (
        .clk(clk), .rst(rst2), .req(req2), .we(we), .addr(addr),
        .data_in(data_in), .be(be), .ready(ready2), .data_out(data_out2),
        .rvalid(rvalid2), .err(err2)
    );

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge, then sample; the scoreboard consumes read results.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got rvalid=1 data 0x%0h, expected no read", data_out);
            end else begin
                chk("sb_read_data", {16'h0, data_out}, {16'h0, sb_q.pop_front()});
            end
        end
    endtask

    task automatic count_not_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n <= 1000) begin
            n++;
            tick();
        end
    endtask

    task automatic read1(input logic [7:0] a, input logic [15:0] exp);
        req = 1'b1; we = 1'b0; addr = a; be = 2'b00;
        sb_q.push_back(exp);
        tick();
        req = 1'b0;
        chk("read_rvalid", {31'h0, rvalid}, 32'h1);
    endtask

    initial begin
        int n;
        rst = 1'b1; rst2 = 1'b1; req = 1'b0; req2 = 1'b0;
        we = 1'b0; addr = '0; data_in = '0; be = '0;

        // Table: reads carry their expected data.
        vecs[0]  = '{1'b0, 8'hFF, 16'h0000, 2'b00, 16'h0000};
        vecs[1]  = '{1'b1, 8'h12, 16'hA5C3, 2'b11, 16'h0000};
        vecs[2]  = '{1'b0, 8'h12, 16'h0000, 2'b00, 16'hA5C3};
        vecs[3]  = '{1'b1, 8'h05, 16'h1234, 2'b11, 16'h0000};
        vecs[4]  = '{1'b1, 8'h05, 16'hFFEE, 2'b01, 16'h0000};
        vecs[5]  = '{1'b0, 8'h05, 16'h0000, 2'b00, 16'h12EE};
        vecs[6]  = '{1'b1, 8'h05, 16'hABCD, 2'b10, 16'h0000};
        vecs[7]  = '{1'b0, 8'h05, 16'h0000, 2'b00, 16'hABEE};
        vecs[8]  = '{1'b1, 8'h05, 16'h5555, 2'b00, 16'h0000};
        vecs[9]  = '{1'b0, 8'h05, 16'h0000, 2'b00, 16'hABEE};
        vecs[10] = '{1'b1, 8'h01, 16'h0111, 2'b11, 16'h0000};
        vecs[11] = '{1'b1, 8'h02, 16'h0222, 2'b11, 16'h0000};
        vecs[12] = '{1'b1, 8'h03, 16'h0333, 2'b11, 16'h0000};
        vecs[13] = '{1'b0, 8'h01, 16'h0000, 2'b00, 16'h0111};
        vecs[14] = '{1'b0, 8'h02, 16'h0000, 2'b00, 16'h0222};
        vecs[15] = '{1'b0, 8'h03, 16'h0000, 2'b00, 16'h0333};
        vecs[16] = '{1'b0, 8'h00, 16'h0000, 2'b00, 16'h0000};
        vecs[17] = '{1'b0, 8'h12, 16'h0000, 2'b00, 16'hA5C3};
        vecs[18] = '{1'b1, 8'hFF, 16'hC0DE, 2'b11, 16'h0000};
        vecs[19] = '{1'b0, 8'hFF, 16'h0000, 2'b00, 16'hC0DE};

        // Reset two cycles, with a request present to show it is ignored.
        req = 1'b1; we = 1'b1;
        tick(); tick();
        req = 1'b0; we = 1'b0;
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_data_out", {16'h0, data_out}, 32'h0);
        rst = 1'b0;

        count_not_ready(n);
        chk("clear_cycles", n, 256);

        // Table-driven pass; requests are back-to-back.
        for (int i = 0; i < 20; i++) begin
            req = 1'b1; we = vecs[i].we; addr = vecs[i].addr;
            data_in = vecs[i].data; be = vecs[i].be;
            if (!vecs[i].we) sb_q.push_back(vecs[i].exp);
            tick();
            chk(vecs[i].we ? "write_no_rvalid" : "read_rvalid", {31'h0, rvalid}, {31'h0, ~vecs[i].we});
        end
        req = 1'b0;
        tick();
        chk("idle_rvalid", {31'h0, rvalid}, 32'h0);
        chk("idle_hold", {16'h0, data_out}, 32'h0000C0DE);
        chk("run_err", {31'h0, err}, 32'h0);

        // Request during CLEAR: ignored, err sticks.
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_clears_dout", {16'h0, data_out}, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        req = 1'b1; we = 1'b1; addr = 8'h10; data_in = 16'hFFFF; be = 2'b11;
        tick();
        req = 1'b0; we = 1'b0;
        chk("clear_req_err", {31'h0, err}, 32'h1);
        chk("clear_req_no_rvalid", {31'h0, rvalid}, 32'h0);
        count_not_ready(n);
        chk("clear_cycles_after_req", n, 256 - 6);
        chk("err_sticky", {31'h0, err}, 32'h1);
        read1(8'h10, 16'h0000);
        rst = 1'b1; tick();
        chk("rst_err_clears", {31'h0, err}, 32'h0);
        chk("rst_ready_low", {31'h0, ready}, 32'h0);
        rst = 1'b0;

        // Reset at clear count 100 restarts the full sweep.
        for (int i = 0; i < 100; i++) tick();
        chk("mid_clear_ready", {31'h0, ready}, 32'h0);
        rst = 1'b1; tick(); rst = 1'b0;
        count_not_ready(n);
        chk("restart_clear_cycles", n, 256);
        read1(8'h05, 16'h0000);

        // Retention build: no sweep, contents persist, in-flight read cancelled.
        rst2 = 1'b0;
        n = 0;
        while (ready2 !== 1'b1 && n < 10) begin n++; tick(); end
        chk("nc_ready_soon", {31'h0, ready2}, 32'h1);
        req2 = 1'b1; we = 1'b1; addr = 8'h20; data_in = 16'hBEEF; be = 2'b11;
        tick();
        we = 1'b0; rst2 = 1'b1;
        tick();
        req2 = 1'b0; rst2 = 1'b0;
        chk("nc_rst_cancels_read", {31'h0, rvalid2}, 32'h0);
        chk("nc_rst_dout", {16'h0, data_out2}, 32'h0);
        n = 0;
        while (ready2 !== 1'b1 && n < 10) begin n++; tick(); end
        chk("nc_ready_after_rst", {31'h0, ready2}, 32'h1);
        req2 = 1'b1; we = 1'b0; addr = 8'h20;
        tick();
        req2 = 1'b0;
        chk("nc_read_rvalid", {31'h0, rvalid2}, 32'h1);
        chk("nc_persist", {16'h0, data_out2}, 32'h0000BEEF);
        tick();
        chk("nc_rvalid_pulse", {31'h0, rvalid2}, 32'h0);

        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
